// File: rtl/ifetch.sv
// Instruction fetch unit: keeps the fetch PC, issues one word read at a time to
// the memory controller and pushes returned instructions into the instruction queue.
// Branch/jump redirects discard whatever fetch is in flight.
// Optional direct-mapped one-word-per-line instruction cache enabled by defining ICACHE_EN.
module ifetch #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        inst_rdy,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  input  logic        iqueue_full,
  input  logic        jump_en,
  input  logic [31:0] jump_pc
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        mem_req_next;
  logic [31:0] mem_addr_next;
  logic        inst_rdy_next;
  logic [31:0] inst_next;
  logic [31:0] pc_out_next;

  logic [31:0] jump_target;
  logic        cache_hit;
  logic [31:0] cache_data;

  assign jump_target = jump_pc & 32'hFFFF_FFFC;

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]             line_data  [ICACHE_LINES];
  logic [TAG_W-1:0]        line_tag   [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] line_valid;

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             fill;

  assign rd_idx     = pc[IDX_W+1:2];
  assign rd_tag     = pc[31:IDX_W+2];
  assign wr_idx     = mem_addr[IDX_W+1:2];
  assign wr_tag     = mem_addr[31:IDX_W+2];
  assign fill       = rdy && mem_req && mem_done;
  assign cache_hit  = line_valid[rd_idx] && (line_tag[rd_idx] == rd_tag);
  assign cache_data = line_data[rd_idx];

  // Valid bits: cleared on reset, set by every memory response, even discarded ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid <= '0;
    end else if (fill) begin
      line_valid[wr_idx] <= 1'b1;
    end
  end

  // Line data and tag storage, written alongside the valid bit
  always_ff @(posedge clk) begin
    if (fill) begin
      line_data[wr_idx] <= mem_data;
      line_tag[wr_idx]  <= wr_tag;
    end
  end
`else
  logic unused_cfg;

  assign cache_hit  = 1'b0;
  assign cache_data = 32'h0;
  assign unused_cfg = ^ICACHE_LINES;
`endif

  // State register; rdy low freezes the machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_next;
    end
  end

  // Next-state: start a fetch from IDLE, return to IDLE on any memory response,
  // park in DROP when a redirect arrives while a request is still outstanding
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!jump_en && !iqueue_full && !cache_hit) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_done) begin
          state_next = IDLE;
        end else if (jump_en) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (mem_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of PC, request and push outputs; the push strobe is a single-cycle pulse
  always_comb begin
    pc_next       = pc;
    mem_req_next  = mem_req;
    mem_addr_next = mem_addr;
    inst_rdy_next = 1'b0;
    inst_next     = inst;
    pc_out_next   = pc_out;
    case (state)
      IDLE: begin
        if (jump_en) begin
          pc_next = jump_target;
        end else if (!iqueue_full) begin
          if (cache_hit) begin
            inst_next     = cache_data;
            pc_out_next   = pc;
            inst_rdy_next = 1'b1;
            pc_next       = pc + 32'd4;
          end else begin
            mem_req_next  = 1'b1;
            mem_addr_next = pc;
          end
        end
      end
      WAIT: begin
        if (mem_done) begin
          mem_req_next = 1'b0;
          if (jump_en) begin
            pc_next = jump_target;
          end else begin
            inst_next     = mem_data;
            pc_out_next   = pc;
            inst_rdy_next = 1'b1;
            pc_next       = pc + 32'd4;
          end
        end else if (jump_en) begin
          pc_next = jump_target;
        end
      end
      DROP: begin
        if (jump_en) begin
          pc_next = jump_target;
        end
        if (mem_done) begin
          mem_req_next = 1'b0;
        end
      end
      default: begin
        mem_req_next = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset abandons any request in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      inst_rdy <= 1'b0;
      inst     <= 32'h0;
      pc_out   <= 32'h0;
    end else if (rdy) begin
      pc       <= pc_next;
      mem_req  <= mem_req_next;
      mem_addr <= mem_addr_next;
      inst_rdy <= inst_rdy_next;
      inst     <= inst_next;
      pc_out   <= pc_out_next;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed scenarios plus randomized traffic checked against
// a transaction-level reference model of the fetch PC and push stream.
// Cache scenario runs only when ICACHE_EN is defined.
module tb_ifetch;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic        iqueue_full;
  logic        jump_en;
  logic [31:0] jump_pc;

  int checks   = 0;
  int failures = 0;

  // Memory responder state
  bit          mem_busy;
  bit          mem_answered;
  int          mem_cnt;
  int          mem_lat = 1;
  bit          mem_rand_lat = 1'b0;
  bit          jump_with_done = 1'b0;
  logic [31:0] jwd_pc;

  // Reference model state
  bit          model_on = 1'b1;
  logic [31:0] m_pc;
  bit          m_req;
  bit          m_squash;
  logic [31:0] m_req_addr;
  bit          m_inst_rdy;
  logic [31:0] exp_inst;
  logic [31:0] exp_pcout;

  // Observation logs
  logic [31:0] seen_pc[$];
  logic [31:0] seen_inst[$];
  logic [31:0] seen_addr[$];

  bit          r_rdy;
  bit          r_full;
  bit          r_jump;

  ifetch #(
    .RESET_PC(RESET_PC),
    .ICACHE_LINES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_done(mem_done),
    .mem_data(mem_data),
    .inst_rdy(inst_rdy),
    .inst(inst),
    .pc_out(pc_out),
    .iqueue_full(iqueue_full),
    .jump_en(jump_en),
    .jump_pc(jump_pc)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00000013;
      32'h4:   return 32'h00100093;
      32'h8:   return 32'h00200113;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endcase
  endfunction

  task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task modelReset;
    m_pc         = RESET_PC;
    m_req        = 1'b0;
    m_squash     = 1'b0;
    m_inst_rdy   = 1'b0;
    mem_busy     = 1'b0;
    mem_answered = 1'b0;
    mem_cnt      = 0;
  endtask

  task doReset;
    rst         = 1'b1;
    rdy         = 1'b1;
    iqueue_full = 1'b0;
    jump_en     = 1'b0;
    jump_pc     = 32'h0;
    mem_done    = 1'b0;
    mem_data    = 32'h0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of stimulus: called at a negedge, drives inputs, lets the edge happen,
  // advances the reference model and checks outputs at the following negedge
  task applyStimulus(input bit rdy_v, input bit full_v, input bit jump_v, input logic [31:0] jpc);
    bit          s_rdy;
    bit          s_full;
    bit          s_jump;
    bit          s_done;
    bit          s_req;
    bit          exp_push;
    logic [31:0] s_jpc;
    logic [31:0] s_data;
    rdy         = rdy_v;
    iqueue_full = full_v;
    jump_en     = jump_v;
    jump_pc     = jpc;
    mem_done    = 1'b0;
    if (!mem_req) begin
      mem_busy     = 1'b0;
      mem_answered = 1'b0;
    end else if (!mem_busy) begin
      mem_busy     = 1'b1;
      mem_answered = 1'b0;
      mem_cnt      = mem_rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
    end
    if (mem_busy && !mem_answered && rdy_v) begin
      if (mem_cnt == 0) begin
        mem_done     = 1'b1;
        mem_data     = memWord(mem_addr);
        mem_answered = 1'b1;
        if (jump_with_done) begin
          jump_en        = 1'b1;
          jump_pc        = jwd_pc;
          jump_with_done = 1'b0;
        end
      end else begin
        mem_cnt--;
      end
    end
    s_rdy  = rdy;
    s_full = iqueue_full;
    s_jump = jump_en;
    s_jpc  = jump_pc;
    s_done = mem_done;
    s_data = mem_data;
    s_req  = mem_req;
    @(posedge clk);
    exp_push = 1'b0;
    if (s_rdy) begin
      if (m_req) begin
        if (s_done) begin
          if (!s_jump && !m_squash) begin
            exp_push  = 1'b1;
            exp_inst  = s_data;
            exp_pcout = m_req_addr;
            m_pc      = m_req_addr + 32'd4;
          end
          m_req    = 1'b0;
          m_squash = 1'b0;
        end else if (s_jump) begin
          m_squash = 1'b1;
        end
        if (s_jump) m_pc = s_jpc & 32'hFFFF_FFFC;
      end else if (s_jump) begin
        m_pc = s_jpc & 32'hFFFF_FFFC;
      end else if (!s_full) begin
        m_req      = 1'b1;
        m_req_addr = m_pc;
      end
      m_inst_rdy = exp_push;
    end
    @(negedge clk);
    mem_done = 1'b0;
    jump_en  = 1'b0;
    if (model_on) begin
      checkOutput("mem_req", {31'b0, mem_req}, {31'b0, m_req});
      if (m_req) checkOutput("mem_addr", mem_addr, m_req_addr);
      checkOutput("inst_rdy", {31'b0, inst_rdy}, {31'b0, m_inst_rdy});
      if (s_rdy && m_inst_rdy) begin
        checkOutput("inst", inst, exp_inst);
        checkOutput("pc_out", pc_out, exp_pcout);
      end
    end
    if (s_rdy && inst_rdy) begin
      seen_pc.push_back(pc_out);
      seen_inst.push_back(inst);
    end
    if (mem_req && !s_req) seen_addr.push_back(mem_addr);
  endtask

  task waitPush(input bit full_v, input int budget, input string tag);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      applyStimulus(1'b1, full_v, 1'b0, 32'h0);
      n++;
      got = inst_rdy;
    end
    checkOutput(tag, {31'b0, got}, 32'h1);
  endtask

  task waitIdle(input int budget, input string tag);
    int n;
    n = 0;
    while (mem_req && n < budget) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    checkOutput(tag, {31'b0, mem_req}, 32'h0);
  endtask

  // Main sequence
  initial begin
    int npush;
    rst = 1'b1;
    doReset();
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_inst_rdy", {31'b0, inst_rdy}, 32'h0);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_pc_out", pc_out, 32'h0);

    $display("[TB] sequential fetch");
    mem_rand_lat = 1'b0;
    mem_lat      = 1;
    for (int k = 0; k < 3; k++) waitPush(1'b0, 20, "seq_push_timeout");
    checkOutput("seq_addr0", seen_addr[0], 32'h0);
    checkOutput("seq_addr1", seen_addr[1], 32'h4);
    checkOutput("seq_addr2", seen_addr[2], 32'h8);
    checkOutput("seq_pc0", seen_pc[0], 32'h0);
    checkOutput("seq_pc1", seen_pc[1], 32'h4);
    checkOutput("seq_pc2", seen_pc[2], 32'h8);
    checkOutput("seq_inst0", seen_inst[0], 32'h00000013);
    checkOutput("seq_inst1", seen_inst[1], 32'h00100093);
    checkOutput("seq_inst2", seen_inst[2], 32'h00200113);

    $display("[TB] queue full backpressure");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("full_no_req", {31'b0, mem_req}, 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("full_release_req", {31'b0, mem_req}, 32'h1);
    checkOutput("full_release_addr", mem_addr, 32'hC);
    waitPush(1'b1, 20, "full_inflight_push");
    checkOutput("full_inflight_pc", seen_pc[$], 32'hC);

    $display("[TB] redirect while waiting");
    mem_lat = 2;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    npush = seen_pc.size();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h103);
    waitIdle(20, "drop_timeout");
    checkOutput("drop_no_push", npush, seen_pc.size());
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redirect_addr", mem_addr, 32'h100);
    waitPush(1'b0, 20, "redirect_push");
    checkOutput("redirect_pc", seen_pc[$], 32'h100);

    $display("[TB] redirect with response and repeated redirects");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    npush          = seen_pc.size();
    jwd_pc         = 32'h200;
    jump_with_done = 1'b1;
    waitIdle(20, "jwd_timeout");
    checkOutput("jwd_no_push", npush, seen_pc.size());
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("jwd_addr", mem_addr, 32'h200);
    mem_lat = 3;
    waitPush(1'b0, 20, "jwd_push");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    npush = seen_pc.size();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h2F0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h300);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h400);
    waitIdle(20, "multi_drop_timeout");
    checkOutput("multi_drop_no_push", npush, seen_pc.size());
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("multi_drop_addr", mem_addr, 32'h400);

    $display("[TB] async reset mid fetch");
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("arst_mem_addr", mem_addr, 32'h0);
    checkOutput("arst_inst_rdy", {31'b0, inst_rdy}, 32'h0);
    checkOutput("arst_pc_out", pc_out, 32'h0);
    modelReset();
    @(negedge clk);
    rst     = 1'b0;
    mem_lat = 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("arst_first_req", {31'b0, mem_req}, 32'h1);
    checkOutput("arst_first_addr", mem_addr, RESET_PC);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, k == 1, 32'h500);
      checkOutput("stall_req_hold", {31'b0, mem_req}, 32'h1);
      checkOutput("stall_no_push", {31'b0, inst_rdy}, 32'h0);
    end
    waitPush(1'b0, 20, "stall_push");
    checkOutput("stall_pc", seen_pc[$], RESET_PC);
    checkOutput("stall_inst", seen_inst[$], 32'h00000013);

`ifndef ICACHE_EN
    $display("[TB] pc wraparound");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    waitPush(1'b0, 20, "wrap_push_top");
    checkOutput("wrap_pc_top", seen_pc[$], 32'hFFFF_FFFC);
    waitPush(1'b0, 20, "wrap_push_zero");
    checkOutput("wrap_pc_zero", seen_pc[$], 32'h0);

    $display("[TB] randomized traffic");
    mem_rand_lat = 1'b1;
    for (int i = 0; i < 600; i++) begin
      r_rdy  = ($urandom_range(0, 3) != 0);
      r_full = ($urandom_range(0, 3) == 0);
      r_jump = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) begin
        jump_with_done = 1'b1;
        jwd_pc         = $urandom;
      end
      applyStimulus(r_rdy, r_full, r_jump, $urandom);
    end
    jump_with_done = 1'b0;
`else
    $display("[TB] instruction cache");
    doReset();
    mem_rand_lat = 1'b0;
    mem_lat      = 0;
    for (int k = 0; k < 3; k++) waitPush(1'b0, 20, "cache_fill_push");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
    model_on = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("hit_inst_rdy", {31'b0, inst_rdy}, 32'h1);
      checkOutput("hit_pc_out", pc_out, 32'(4 * k));
      checkOutput("hit_inst", inst, memWord(32'(4 * k)));
      checkOutput("hit_no_req", {31'b0, mem_req}, 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    checkOutput("alias_jump_no_push", {31'b0, inst_rdy}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("alias_miss_req", {31'b0, mem_req}, 32'h1);
    checkOutput("alias_miss_addr", mem_addr, 32'h40);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch unit: the producer side of the instruction-queue push interface.
- Holds the architectural fetch PC and issues word reads to the memory controller.
- Pushes each returned instruction and its PC into the instruction queue as a one-cycle pulse.
- Honours the queue's full flag and redirects on branch/jump resolution, discarding any fetch that is in flight at that moment.

Parameters:
RESET_PC, 32'h0, fetch PC loaded on reset.
ICACHE_LINES, 16, number of one-word lines in the optional instruction cache (power of 2); unused unless ICACHE_EN is defined.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
rdy  input  1  global enable; when low, all state and outputs hold.
mem_req  output  1  fetch request to memory controller, level, held until mem_done.
mem_addr  output  32  word-aligned fetch address; valid while mem_req=1.
mem_done  input  1  one-cycle pulse: mem_data is valid for the current request.
mem_data  input  32  returned instruction word.
inst_rdy  output  1  one-cycle push strobe to instruction queue.
inst  output  32  instruction pushed; valid when inst_rdy=1.
pc_out  output  32  PC of pushed instruction; valid when inst_rdy=1.
iqueue_full  input  1  queue near-full (asserted with at least 2 free slots remaining).
jump_en  input  1  one-cycle redirect request.
jump_pc  input  32  redirect target; bits [1:0] are forced to 0.

Behaviour:
- Reset (async, immediate on rst high):
  - pc=RESET_PC, state=IDLE.
  - mem_req=0, mem_addr=0, inst_rdy=0, inst=0, pc_out=0.
  - With ICACHE_EN, all cache valid bits are cleared.
  - Reset mid-fetch abandons the request; the memory controller is reset by the same signal.
- rdy=0: no state changes. inst_rdy holds its value; the memory controller never pulses mem_done while rdy=0.
- inst_rdy defaults to 0 every enabled cycle unless a push occurs; it is never high two cycles in a row from a memory fetch.
- States IDLE, WAIT, DROP:
  - IDLE, jump_en=1: pc<=jump_pc&~3, stay IDLE, no request.
  - IDLE, iqueue_full=1: stay IDLE, no request.
  - IDLE, otherwise: mem_req<=1, mem_addr<=pc, go WAIT.
  - WAIT, mem_done=1, jump_en=0:
    - inst<=mem_data, pc_out<=pc, inst_rdy<=1.
    - pc<=pc+4 (32-bit wraparound from FFFF_FFFC to 0).
    - mem_req<=0, go IDLE.
  - WAIT, mem_done=1, jump_en=1: no push; pc<=jump_pc&~3, mem_req<=0, go IDLE.
  - WAIT, mem_done=0, jump_en=1: pc<=jump_pc&~3, go DROP; mem_req stays 1 and mem_addr is unchanged.
  - DROP, jump_en=1: pc<=jump_pc&~3 (the latest redirect wins), stay DROP.
  - DROP, mem_done=1: data discarded, no push, mem_req<=0, go IDLE.
- iqueue_full is sampled only in IDLE. A fetch already in flight always completes and pushes, which relies on the queue's 2-slot headroom.
- Latency:
  - Request issued 1 cycle after entering IDLE.
  - inst_rdy is asserted on the edge following the one where mem_done is sampled.
  - Minimum 3 cycles per instruction with 1-cycle memory.
- Each fetch has at most one outstanding request.

Optional Feature:
Macro ICACHE_EN enables a direct-mapped instruction cache.
- Organisation: ICACHE_LINES lines of one word each. index=pc[log2(ICACHE_LINES)+1:2], tag=remaining upper bits of pc, one valid bit per line.
- Hit: in IDLE with iqueue_full=0 and jump_en=0:
  - inst<=line data, pc_out<=pc, inst_rdy<=1, pc<=pc+4, stay IDLE, no mem_req.
  - Sustains 1 instruction per cycle.
- Miss: normal memory fetch.
- Fill: every mem_done fills the line for mem_addr, including responses discarded in WAIT or DROP.
- Without ICACHE_EN: no storage, and every fetch goes to memory.

Test Plan:
1. Reset; memory asserts mem_done 2 cycles after mem_req, returning 32'h00000013, 32'h00100093, 32'h00200113 -> mem_addr 0, 4, 8 in order; three inst_rdy pulses with pc_out 0, 4, 8 and matching inst.
2. Hold iqueue_full=1 in IDLE for 5 cycles -> mem_req stays 0. Release -> next cycle mem_req=1 with mem_addr=current pc. Assert iqueue_full during WAIT -> that fetch still pushes.
3. jump_en with jump_pc=32'h103 one cycle after mem_req (WAIT) -> following mem_done produces no inst_rdy; next mem_addr=32'h100, pc_out=32'h100.
4. jump_en (jump_pc=32'h200) in the same cycle as mem_done -> no push; next mem_addr=32'h200. Two jumps while in DROP (0x300 then 0x400) -> next mem_addr=32'h400.
5. Assert rst mid-WAIT, between clock edges -> mem_req, inst_rdy, pc_out go to 0 without a clock edge; first request after release is at RESET_PC. rdy=0 for 4 cycles mid-WAIT -> no state change.
6. ICACHE_EN, ICACHE_LINES=16: loop 0,4,8 then jump_en to 0 -> second pass issues no mem_req, inst_rdy high 3 consecutive cycles with pc_out 0, 4, 8. Fetch 32'h40 (aliases index 0) -> miss, mem_req issued.
